// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file access controller.
package regfile_ctrl_pkg;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 2 ** AW;

   localparam logic [DW-1:0] CLR_VAL_DEF = 8'h00;

   // Controller state: normal arbitration or clear sweep.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   // Requester identity, used for round-robin bookkeeping.
   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win the last accepted transfer is chosen.
module rr_arb2
   import regfile_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   req_id_e last_q, last_d;

   // One-hot grant from current requests and the last winner.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_q == REQ_B) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // The winner is remembered only when a transfer is actually accepted.
   always_comb begin
      last_d = last_q;
      if (accept) begin
         last_d = gnt[1] ? REQ_B : REQ_A;
      end
   end

   // Reset to B so that A wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= REQ_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// Round-robin access controller and clear sequencer for a 16x8 register
// file with synchronous write and asynchronous read.
//
// Handshake: a transfer on port x happens on a rising edge where
// x_valid & x_ready. x_ready is a combinational grant and at most one port
// is ready per cycle. A requester holds x_valid, x_we, x_addr and x_wdata
// stable until accepted and never derives x_valid from x_ready. An accepted
// read returns x_rdata with a one-cycle x_rvalid pulse on the next cycle.
module regfile_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter logic [DW-1:0] CLR_VAL = CLR_VAL_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   input  logic          clr_req,
   output logic          busy,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          arb_en;
   logic [1:0]    arb_req;
   logic [1:0]    gnt;
   logic          a_rvalid_q, b_rvalid_q;
   logic [DW-1:0] a_rdata_q, b_rdata_q;
   logic          a_rd_acc, b_rd_acc;

   // Requests reach the arbiter only in IDLE with no pending clear, and never
   // while reset is asserted, so nothing is granted or written during reset.
   assign arb_en  = rst_n && (state_q == IDLE) && !clr_req;
   assign arb_req = {b_valid, a_valid} & {2{arb_en}};

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (arb_req),
      .accept (|gnt),
      .gnt    (gnt)
   );

   assign a_ready  = gnt[0];
   assign b_ready  = gnt[1];
   assign a_rd_acc = gnt[0] & ~a_we;
   assign b_rd_acc = gnt[1] & ~b_we;
   assign busy     = (state_q == CLEAR);

   // Next state: IDLE starts a sweep on clr_req; CLEAR walks every entry once.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and sweep counter; reset aborts any sweep in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Memory port mux: sweep owns the port in CLEAR, otherwise the granted port.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      if (state_q == CLEAR) begin
         mem_we   = 1'b1;
         mem_addr = cnt_q;
         mem_din  = CLR_VAL;
      end else if (gnt[0]) begin
         mem_we   = a_we;
         mem_addr = a_addr;
         mem_din  = a_wdata;
      end else if (gnt[1]) begin
         mem_we   = b_we;
         mem_addr = b_addr;
         mem_din  = b_wdata;
      end
   end

   // Read return: capture the async read data at the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= a_rd_acc;
         b_rvalid_q <= b_rd_acc;
         if (a_rd_acc) begin
            a_rdata_q <= mem_dout;
         end
         if (b_rd_acc) begin
            b_rdata_q <= mem_dout;
         end
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: directed scenarios plus a randomized run against a
// behavioural reference model of the register file and arbitration rules.
module tb_regfile_ctrl;
   import regfile_ctrl_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_valid, a_we, b_valid, b_we, clr_req;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ready, b_ready, a_rvalid, b_rvalid, busy;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_dout;

   regfile_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_wdata  (a_wdata),
      .a_rvalid (a_rvalid),
      .a_rdata  (a_rdata),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_rvalid (b_rvalid),
      .b_rdata  (b_rdata),
      .clr_req  (clr_req),
      .busy     (busy),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout)
   );

   // Clock
   always #5 clk = ~clk;

   // The register file itself: synchronous write, asynchronous read.
   logic [DW-1:0] rf [DEPTH];
   always @(posedge clk) begin
      if (mem_we) rf[mem_addr] <= mem_din;
   end
   assign mem_dout = rf[mem_addr];

   // Counters
   int total = 0;
   int bad   = 0;

   // Reference model: expected memory contents, last winner (0=A, 1=B),
   // remaining sweep cycles, and expected read-return data per port.
   logic [DW-1:0] ref_mem [DEPTH];
   int            m_last = 1;
   int            m_clr_left = 0;
   logic [DW-1:0] exp_a_q [$];
   logic [DW-1:0] exp_b_q [$];

   // Expected one-hot grant {B,A} from the arbitration rules.
   function automatic logic [1:0] pred_gnt();
      if (!rst_n || m_clr_left > 0 || clr_req) return 2'b00;
      if (a_valid && b_valid) return (m_last == 1) ? 2'b01 : 2'b10;
      return {b_valid, a_valid};
   endfunction

   // Advance the model by one clock edge given the grant of that cycle.
   task automatic model_commit(input logic [1:0] g);
      if (m_clr_left > 0) begin
         ref_mem[DEPTH - m_clr_left] = 8'h00;
         m_clr_left--;
      end else if (clr_req) begin
         m_clr_left = DEPTH;
      end else if (g[0]) begin
         m_last = 0;
         if (a_we) ref_mem[a_addr] = a_wdata;
         else exp_a_q.push_back(ref_mem[a_addr]);
      end else if (g[1]) begin
         m_last = 1;
         if (b_we) ref_mem[b_addr] = b_wdata;
         else exp_b_q.push_back(ref_mem[b_addr]);
      end
   endtask

   task automatic model_reset();
      m_last = 1;
      m_clr_left = 0;
      exp_a_q.delete();
      exp_b_q.delete();
   endtask

   // Driver tasks
   task automatic idle_inputs();
      a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      clr_req = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Write one entry through port A with no other traffic.
   task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      logic [1:0] g;
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data;
      g = pred_gnt();
      @(posedge clk);
      model_commit(g);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      a_valid = 1'b1;
      a_addr = 4'd3;
      #12;
      total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b want=0", a_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if ({a_rvalid, b_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid got=%b want=00", {a_rvalid, b_rvalid}); end
      total++; if ({a_rdata, b_rdata} !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", {a_rdata, b_rdata}); end
      @(negedge clk);
      rst_n = 1'b1;
      a_valid = 1'b0;
      model_reset();
      #1;
      total++; if ({b_ready, a_ready, mem_we} !== 3'b000) begin bad++; $display("FAIL idle_outputs got=%b want=000", {b_ready, a_ready, mem_we}); end
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) begin
         write_a(AW'(i), (i == 3) ? 8'h5A : 8'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_single_read();
      logic [1:0] g;
      apply_reset();
      @(negedge clk);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd3;
      g = pred_gnt();
      #1;
      total++; if ({b_ready, a_ready} !== 2'b01) begin bad++; $display("FAIL single_read_ready got=%b want=01", {b_ready, a_ready}); end
      total++; if ({mem_we, mem_addr} !== {1'b0, 4'd3}) begin bad++; $display("FAIL single_read_mem got=%b/%0d want=0/3", mem_we, mem_addr); end
      @(posedge clk);
      model_commit(g);
      #1;
      a_valid = 1'b0;
      void'(exp_a_q.pop_front());
      total++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h5A) begin bad++; $display("FAIL single_read_data got=%b/%h want=1/5a", a_rvalid, a_rdata); end
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL single_read_b_rvalid got=%b want=0", b_rvalid); end
      @(posedge clk);
      #1;
      total++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h5A) begin bad++; $display("FAIL single_read_pulse got=%b/%h want=0/5a", a_rvalid, a_rdata); end
   endtask

   task automatic test_alternate();
      logic [1:0] g;
      logic [1:0] want;
      logic [DW-1:0] exp_d;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd1;
         b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd2;
         g = pred_gnt();
         want = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         total++; if ({b_ready, a_ready} !== want) begin bad++; $display("FAIL alternate_grant[%0d] got=%b want=%b", i, {b_ready, a_ready}, want); end
         @(posedge clk);
         model_commit(g);
         #1;
         exp_d = (i % 2 == 0) ? ref_mem[1] : ref_mem[2];
         exp_a_q.delete(); exp_b_q.delete();
         total++;
         if ({b_rvalid, a_rvalid} !== want || ((i % 2 == 0) ? a_rdata : b_rdata) !== exp_d) begin
            bad++;
            $display("FAIL alternate_return[%0d] got=%b/%h/%h want=%b/%h", i, {b_rvalid, a_rvalid}, a_rdata, b_rdata, want, exp_d);
         end
      end
      idle_inputs();
   endtask

   task automatic test_write_read_b();
      logic [1:0] g;
      @(negedge clk);
      idle_inputs();
      b_valid = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'hC3;
      g = pred_gnt();
      #1;
      total++; if ({b_ready, mem_we, mem_addr, mem_din} !== {2'b11, 4'd7, 8'hC3}) begin bad++; $display("FAIL wr_b_mem got=%b%b/%0d/%h want=11/7/c3", b_ready, mem_we, mem_addr, mem_din); end
      @(posedge clk);
      model_commit(g);
      #1;
      total++; if (b_rvalid !== 1'b0) begin bad++; $display("FAIL wr_b_no_rvalid got=%b want=0", b_rvalid); end
      @(negedge clk);
      b_we = 1'b0;
      g = pred_gnt();
      @(posedge clk);
      model_commit(g);
      #1;
      void'(exp_b_q.pop_front());
      total++; if (b_rvalid !== 1'b1 || b_rdata !== 8'hC3) begin bad++; $display("FAIL wr_then_rd_b got=%b/%h want=1/c3", b_rvalid, b_rdata); end
      idle_inputs();
   endtask

   task automatic test_clear();
      logic [1:0] g;
      @(negedge clk);
      clr_req = 1'b1;
      a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd5;
      g = pred_gnt();
      #1;
      total++; if ({a_ready, mem_we, busy} !== 3'b000) begin bad++; $display("FAIL clr_start got=%b want=000", {a_ready, mem_we, busy}); end
      @(posedge clk);
      model_commit(g);
      #1;
      for (int k = 0; k < DEPTH; k++) begin
         @(negedge clk);
         clr_req = (k >= 6 && k <= 9);
         g = pred_gnt();
         #1;
         total++;
         if ({busy, a_ready, mem_we, mem_addr, mem_din} !== {3'b101, AW'(k), 8'h00}) begin
            bad++;
            $display("FAIL clr_sweep[%0d] got=%b%b%b/%0d/%h want=101/%0d/00", k, busy, a_ready, mem_we, mem_addr, mem_din, k);
         end
         @(posedge clk);
         model_commit(g);
         #1;
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_end_busy got=%b want=0", busy); end
      @(negedge clk);
      clr_req = 1'b0;
      g = pred_gnt();
      #1;
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL clr_after_grant got=%b want=1", a_ready); end
      @(posedge clk);
      model_commit(g);
      #1;
      void'(exp_a_q.pop_front());
      total++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h00) begin bad++; $display("FAIL clr_read got=%b/%h want=1/00", a_rvalid, a_rdata); end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         a_addr = AW'($urandom_range(0, DEPTH - 1));
         g = pred_gnt();
         @(posedge clk);
         model_commit(g);
         #1;
         void'(exp_a_q.pop_front());
         total++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h00) begin bad++; $display("FAIL clr_read_rand[%0d] got=%b/%h want=1/00", j, a_rvalid, a_rdata); end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_clear();
      logic [1:0] g;
      logic [DW-1:0] saved [DEPTH];
      logic [DW-1:0] want;
      for (int i = 0; i < DEPTH; i++) begin
         saved[i] = 8'($urandom_range(1, 255));
         write_a(AW'(i), saved[i]);
      end
      @(negedge clk);
      clr_req = 1'b1;
      g = pred_gnt();
      @(posedge clk);
      model_commit(g);
      #1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         clr_req = 1'b0;
         a_valid = 1'b1; b_valid = 1'b1;
         g = pred_gnt();
         @(posedge clk);
         model_commit(g);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({busy, a_ready, b_ready, mem_we} !== 4'b0000) begin bad++; $display("FAIL rst_mid_clr got=%b want=0000", {busy, a_ready, b_ready, mem_we}); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         b_valid = 1'b1; b_we = 1'b0; b_addr = AW'(i);
         g = pred_gnt();
         @(posedge clk);
         model_commit(g);
         #1;
         void'(exp_b_q.pop_front());
         want = (i < 5) ? 8'h00 : saved[i];
         total++; if (b_rvalid !== 1'b1 || b_rdata !== want) begin bad++; $display("FAIL rst_mid_clr_entry[%0d] got=%b/%h want=1/%h", i, b_rvalid, b_rdata, want); end
      end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [1:0] g;
      logic [1:0] prev_g;
      logic       in_clr;
      int         a_wait, b_wait;
      logic [DW-1:0] e;
      prev_g = 2'b11;
      a_wait = 0; b_wait = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!a_valid || prev_g[0]) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_we = $urandom_range(0, 1) == 1;
            a_addr = AW'($urandom_range(0, DEPTH - 1));
            a_wdata = 8'($urandom_range(0, 255));
         end
         if (!b_valid || prev_g[1]) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_we = $urandom_range(0, 1) == 1;
            b_addr = AW'($urandom_range(0, DEPTH - 1));
            b_wdata = 8'($urandom_range(0, 255));
         end
         clr_req = (m_clr_left == 0) && ($urandom_range(0, 80) == 0);
         in_clr = (m_clr_left > 0);
         g = pred_gnt();
         #1;
         total++; if ({b_ready, a_ready} !== g || busy !== in_clr) begin bad++; $display("FAIL rand_grant[%0d] got=%b busy=%b want=%b busy=%b", c, {b_ready, a_ready}, busy, g, in_clr); end
         if (in_clr) begin
            total++; if ({mem_we, mem_addr, mem_din} !== {1'b1, AW'(DEPTH - m_clr_left), 8'h00}) begin bad++; $display("FAIL rand_sweep[%0d] got=%b/%0d/%h", c, mem_we, mem_addr, mem_din); end
         end else if (g != 2'b00) begin
            total++;
            if ({mem_we, mem_addr} !== (g[0] ? {a_we, a_addr} : {b_we, b_addr})) begin
               bad++; $display("FAIL rand_mem[%0d] got=%b/%0d", c, mem_we, mem_addr);
            end
         end
         if (!in_clr && !clr_req) begin
            if (a_valid) begin
               if (g[0]) begin
                  total++; if (a_wait > 1) begin bad++; $display("FAIL rand_starve_a got=%0d want<=1", a_wait); end
                  a_wait = 0;
               end else a_wait++;
            end
            if (b_valid) begin
               if (g[1]) begin
                  total++; if (b_wait > 1) begin bad++; $display("FAIL rand_starve_b got=%0d want<=1", b_wait); end
                  b_wait = 0;
               end else b_wait++;
            end
         end
         @(posedge clk);
         model_commit(g);
         prev_g = g;
         #1;
         total++; if (a_rvalid !== (exp_a_q.size() > 0) || b_rvalid !== (exp_b_q.size() > 0)) begin bad++; $display("FAIL rand_rvalid[%0d] got=%b%b", c, a_rvalid, b_rvalid); end
         if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            total++; if (a_rdata !== e) begin bad++; $display("FAIL rand_a_rdata[%0d] got=%h want=%h", c, a_rdata, e); end
         end
         if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            total++; if (b_rdata !== e) begin bad++; $display("FAIL rand_b_rdata[%0d] got=%h want=%h", c, b_rdata, e); end
         end
      end
      idle_inputs();
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   // Main sequence and final report
   initial begin
      test_reset();
      preload();
      test_single_read();
      test_alternate();
      test_write_read_b();
      test_clear();
      test_reset_mid_clear();
      test_random();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
